// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter
// Open-drain clk/data drive: inhibit, request-to-send, bit clocking, ACK, timeouts.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2841,
  parameter int REQ_CYCLES     = 16,
  parameter int FILTER_CYCLES  = 8,
  parameter int START_TIMEOUT  = 426135,
  parameter int XFER_TIMEOUT   = 56818
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       done,
  output logic [1:0] err,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam logic [FW-1:0] F_LAST  = FW'(FILTER_CYCLES - 1);
  localparam logic [19:0] INH_LAST  = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] REQ_LAST  = 20'(REQ_CYCLES - 1);
  localparam logic [19:0] STO_LAST  = 20'(START_TIMEOUT - 1);
  localparam logic [19:0] XTO_LAST  = 20'(XFER_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_WAIT,
    S_XFER,
    S_IDLEWAIT,
    S_DONE,
    S_ERR
  } state_t;

  logic          clk_s1, clk_s2;
  logic          dat_s1, dat_s2;
  logic          fclk, fclk_d, fe;
  logic [FW-1:0] fcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      fclk   <= 1'b1;
      fclk_d <= 1'b1;
      fe     <= 1'b0;
      fcnt   <= '0;
    end else begin
      clk_s1 <= ps2_clk_i;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data_i;
      dat_s2 <= dat_s1;
      fclk_d <= fclk;
      fe     <= fclk_d & ~fclk;
      if (clk_s2 == fclk) begin
        fcnt <= '0;
      end else if (fcnt == F_LAST) begin
        fcnt <= '0;
        fclk <= clk_s2;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  state_t      state;
  logic [19:0] cnt;
  logic [9:0]  sh;
  logic [3:0]  bitcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      sh          <= '0;
      bitcnt      <= '0;
      tx_ready    <= 1'b1;
      done        <= 1'b0;
      err         <= 2'd0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      cnt  <= cnt + 20'd1;
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (tx_start) begin
            sh         <= {1'b1, ~^tx_data, tx_data};
            tx_ready   <= 1'b0;
            ps2_clk_oe <= 1'b1;
            state      <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (cnt == INH_LAST) begin
            cnt         <= '0;
            ps2_data_oe <= 1'b1;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (cnt == REQ_LAST) begin
            cnt        <= '0;
            ps2_clk_oe <= 1'b0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (fe) begin
            cnt         <= '0;
            ps2_data_oe <= ~sh[0];
            sh          <= sh >> 1;
            bitcnt      <= 4'd1;
            state       <= S_XFER;
          end else if (cnt == STO_LAST) begin
            cnt         <= '0;
            ps2_data_oe <= 1'b0;
            err         <= 2'd2;
            done        <= 1'b1;
            state       <= S_ERR;
          end
        end
        S_XFER: begin
          if (cnt == XTO_LAST) begin
            cnt         <= '0;
            ps2_data_oe <= 1'b0;
            err         <= 2'd3;
            done        <= 1'b1;
            state       <= S_ERR;
          end else if (fe) begin
            if (bitcnt == 4'd10) begin
              if (dat_s2) begin
                cnt   <= '0;
                err   <= 2'd1;
                done  <= 1'b1;
                state <= S_ERR;
              end else begin
                // count carries on: one budget spans the frame and release
                bitcnt <= 4'd11;
                state  <= S_IDLEWAIT;
              end
            end else begin
              ps2_data_oe <= ~sh[0];
              sh          <= sh >> 1;
              bitcnt      <= bitcnt + 4'd1;
            end
          end
        end
        S_IDLEWAIT: begin
          if (cnt == XTO_LAST) begin
            cnt         <= '0;
            ps2_data_oe <= 1'b0;
            err         <= 2'd3;
            done        <= 1'b1;
            state       <= S_ERR;
          end else if (fclk && dat_s2) begin
            cnt   <= '0;
            err   <= 2'd0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE, S_ERR: begin
          cnt         <= '0;
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          tx_ready    <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a PS/2 device model and done/err scoreboard
// ACK, NACK, both timeouts, ignored start, mid-frame reset, clock glitch
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int REQ  = 4;
  localparam int FILT = 2;
  localparam int STO  = 2000;
  localparam int XTO  = 40000;
  localparam int HP   = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready;
  logic       done;
  logic [1:0] err;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       dev_clk;
  logic       dev_dat;

  int         total = 0;
  int         bad = 0;
  int         done_cnt = 0;
  logic [1:0] exp_q[$];
  logic       prev_done = 1'b0;

  assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_i = dev_dat & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES    (REQ),
    .FILTER_CYCLES (FILT),
    .START_TIMEOUT (STO),
    .XFER_TIMEOUT  (XTO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_ready   (tx_ready),
    .done       (done),
    .err        (err),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (prev_done) chk("ready_after_done", 32'(tx_ready), 1);
    if (done === 1'b1) begin
      done_cnt++;
      chk("done_queued", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("err_code", 32'(err), 32'(exp_q.pop_front()));
      chk("oe_at_done", 32'({ps2_clk_oe, ps2_data_oe}), 0);
    end
    prev_done = (done === 1'b1);
  end

  task automatic start_tx(input logic [7:0] d, input bit push,
                          input logic [1:0] exp_err,
                          output int inh, output int req);
    if (push) exp_q.push_back(exp_err);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = ~d;
    chk("ready_low", 32'(tx_ready), 0);
    chk("clk_oe_high", 32'(ps2_clk_oe), 1);
    inh = 0;
    while (ps2_clk_oe && !ps2_data_oe && inh < 5000) begin
      inh++;
      @(negedge clk);
    end
    req = 0;
    while (ps2_clk_oe && ps2_data_oe && req < 5000) begin
      req++;
      @(negedge clk);
    end
  endtask

  task automatic dev_clock(input int n, input bit ack, input int glitch,
                           output logic [10:0] rx);
    rx = '0;
    rx[0] = ps2_data_i;
    for (int i = 1; i <= n; i++) begin
      for (int k = 0; k < HP; k++) begin
        dev_clk = (i == glitch && k == HP / 2) ? 1'b0 : 1'b1;
        @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (HP) @(negedge clk);
      dev_clk = 1'b1;
      if (i <= 10) rx[i] = ps2_data_i;
      if (i == 10 && ack) dev_dat = 1'b0;
    end
    if (n == 11) begin
      repeat (HP) @(negedge clk);
      dev_dat = 1'b1;
    end
  endtask

  task automatic wait_idle(input int exp_dones, input int budget);
    int k = 0;
    while ((done_cnt < exp_dones || !tx_ready) && k < budget) begin
      k++;
      @(negedge clk);
    end
    chk("done_count", done_cnt, exp_dones);
    chk("ready_idle", 32'(tx_ready), 1);
  endtask

  initial begin
    logic [10:0] rx;
    int inh;
    int req;
    int k;
    reset    = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_dat  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(tx_ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    start_tx(8'hED, 1, 2'd0, inh, req);
    chk("inhibit_cycles", inh, INH);
    chk("req_cycles", req, REQ);
    chk("rts_data_low", 32'(ps2_data_i), 0);
    dev_clock(11, 1, 0, rx);
    chk("frame_ed", 32'(rx), 32'(11'b1_1_11101101_0));
    wait_idle(1, 200);

    start_tx(8'hF4, 1, 2'd0, inh, req);
    chk("inhibit_f4", 32'(inh >= INH), 1);
    chk("req_f4", 32'(req >= REQ), 1);
    dev_clock(11, 1, 3, rx);
    chk("frame_f4_glitch", 32'(rx), 32'(11'b1_0_11110100_0));
    wait_idle(2, 200);

    start_tx(8'h3C, 1, 2'd1, inh, req);
    dev_clock(11, 0, 0, rx);
    chk("frame_3c", 32'(rx), 32'(11'b1_1_00111100_0));
    wait_idle(3, 200);

    start_tx(8'hF4, 1, 2'd2, inh, req);
    k = 0;
    while (!done && k < 3000) begin
      k++;
      @(negedge clk);
    end
    chk("start_timeout_cycles", k, STO);
    wait_idle(4, 50);

    start_tx(8'hAA, 1, 2'd3, inh, req);
    dev_clock(5, 0, 0, rx);
    tx_data  = 8'h11;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_idle(5, XTO + 1000);
    repeat (100) @(negedge clk);
    chk("no_queued_start", 32'({tx_ready, ps2_clk_oe}), 32'(2'b10));
    chk("single_done", done_cnt, 5);

    start_tx(8'h12, 0, 2'd0, inh, req);
    dev_clock(4, 0, 0, rx);
    chk("data_oe_mid", 32'(ps2_data_oe), 1);
    reset = 1'b1;
    #1;
    chk("reset_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
    chk("reset_ready", 32'(tx_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    chk("reset_no_done", done_cnt, 5);
    chk("reset_idle", 32'(tx_ready), 1);
    chk("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
